// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch sequencer and its PC arithmetic.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } fetch_state_t;

    localparam int unsigned IMEM_DEPTH_DEFAULT = 4096;
    localparam int unsigned PC_W_DEFAULT       = 32;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection (hold / branch / increment) with an out-of-range flag.
module pc_next_calc #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned IMEM_DEPTH = 4096
) (
    input  logic [PC_W-1:0] current_pc,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            stall,
    output logic [PC_W-1:0] next_pc,
    output logic            next_illegal
);

    localparam logic [PC_W:0] DEPTH_EXT = (PC_W+1)'(IMEM_DEPTH);

    // One extra bit so that incrementing the all-ones PC cannot wrap into a legal slot.
    logic [PC_W:0] cand;

    always_comb begin
        cand = {1'b0, current_pc} + {{PC_W{1'b0}}, 1'b1};
        if (stall) begin
            cand = {1'b0, current_pc};
        end else if (branch_taken) begin
            cand = {1'b0, branch_target};
        end
        next_pc      = cand[PC_W-1:0];
        next_illegal = (cand >= DEPTH_EXT);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control FSM and registered PC; one fetch per cycle, stall holds PC, zero-bubble branches.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating run_cycles counter.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W       = PC_W_DEFAULT,
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            halt,
    output logic [PC_W-1:0] current_pc,
    output logic            fetch_valid,
    output logic            done,
    output logic            fault
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [31:0]     run_cycles
`endif
);

    localparam logic [PC_W:0] DEPTH_EXT = (PC_W+1)'(IMEM_DEPTH);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] next_pc;
    logic            next_illegal;
    logic            start_illegal;
    logic            start_accept;

    pc_next_calc #(
        .PC_W       (PC_W),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_pc_next (
        .current_pc    (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .next_pc       (next_pc),
        .next_illegal  (next_illegal)
    );

    assign start_illegal = ({1'b0, start_pc} >= DEPTH_EXT);
    assign start_accept  = (state_q != RUN) && start;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            RUN: begin
                // Halt outranks branch; a faulting next PC leaves the last legal PC in place.
                if (!stall) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (next_illegal) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            default: begin
                if (start) begin
                    if (start_illegal) begin
                        state_d = FAULT;
                    end else begin
                        state_d = RUN;
                        pc_d    = start_pc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign current_pc  = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign done        = (state_q == HALTED) || (state_q == FAULT);
    assign fault       = (state_q == FAULT);

`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (start_accept) begin
            cyc_d = '0;
        end else if ((state_q == RUN) && (cyc_q != '1)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign run_cycles = cyc_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequencing, branches, stalls, halt, faults, async reset.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] start_pc;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt;
    logic [31:0] current_pc;
    logic        fetch_valid;
    logic        done;
    logic        fault;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0] run_cycles;
`endif

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_pc      (start_pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .current_pc    (current_pc),
        .fetch_valid   (fetch_valid),
        .done          (done),
        .fault         (fault)
`ifdef FETCH_CYCLE_COUNT_EN
        ,
        .run_cycles    (run_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc,
                           input logic fv, input logic dn, input logic ft);
        check({tag, ".pc"},    current_pc,  pc);
        check({tag, ".valid"}, fetch_valid, fv);
        check({tag, ".done"},  done,        dn);
        check({tag, ".fault"}, fault,       ft);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_pc = '0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
        #1;
        chk_out("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        step(); step();
        reset = 1'b0;
        step();
        chk_out("idle", 32'd0, 1'b0, 1'b0, 1'b0);

        // Sequential fetch from 0
        start = 1'b1; start_pc = 32'd0;
        step();
        start = 1'b0;
        chk_out("seq0", 32'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("seq%0d", i), current_pc, i);
        end

        // Branch at PC 5 to 40, then increment
        branch_taken = 1'b1; branch_target = 32'd40;
        step();
        branch_taken = 1'b0;
        check("br40", current_pc, 32'd40);
        step();
        check("br41", current_pc, 32'd41);

        // Get to PC 10, then stall with halt asserted
        branch_taken = 1'b1; branch_target = 32'd10;
        step();
        branch_taken = 1'b0;
        check("br10", current_pc, 32'd10);
        stall = 1'b1; halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall%0d", i), 32'd10, 1'b1, 1'b0, 1'b0);
        end
        stall = 1'b0;
        step();
        halt = 1'b0;
        chk_out("halt10", 32'd10, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("halt_hold", 32'd10, 1'b0, 1'b1, 1'b0);

        // Last legal slot then increment fault
        start = 1'b1; start_pc = 32'd4095;
        step();
        start = 1'b0;
        chk_out("pc4095", 32'd4095, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("inc_fault", 32'd4095, 1'b0, 1'b1, 1'b1);

        // Branch target out of range
        start = 1'b1; start_pc = 32'd0;
        step();
        start = 1'b0;
        check("restart0", current_pc, 32'd0);
        branch_taken = 1'b1; branch_target = 32'd5000;
        step();
        branch_taken = 1'b0;
        chk_out("br_fault", 32'd0, 1'b0, 1'b1, 1'b1);

        // Out-of-range start_pc: fault, PC keeps prior value
        start = 1'b1; start_pc = 32'd4096;
        step();
        start = 1'b0;
        chk_out("start_fault", 32'd0, 1'b0, 1'b1, 1'b1);

        // Branch to last legal slot is accepted
        start = 1'b1; start_pc = 32'd0;
        step();
        start = 1'b0;
        branch_taken = 1'b1; branch_target = 32'd4095;
        step();
        check("br4095", current_pc, 32'd4095);
        check("br4095.valid", fetch_valid, 1'b1);

        // Halt and branch together: halt wins
        halt = 1'b1; branch_taken = 1'b1; branch_target = 32'd7;
        step();
        halt = 1'b0; branch_taken = 1'b0;
        chk_out("halt_br", 32'd4095, 1'b0, 1'b1, 1'b0);
        start = 1'b1; start_pc = 32'd100;
        step();
        chk_out("start100", 32'd100, 1'b1, 1'b0, 1'b0);

        // start during RUN ignored
        start_pc = 32'd200;
        step();
        start = 1'b0;
        check("run_start_ign", current_pc, 32'd101);

        // Stall suppresses branch
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd300;
        step();
        stall = 1'b0; branch_taken = 1'b0;
        check("stall_br", current_pc, 32'd101);

        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt101", done, 1'b1);

        // 7-cycle run ending in halt, one stalled cycle
        start = 1'b1; start_pc = 32'd0;
        step();
        start = 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
        check("cyc_clear", run_cycles, 32'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            stall = (i == 2);
            step();
        end
        stall = 1'b0;
        check("run7.pc", current_pc, 32'd5);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_out("run7.halt", 32'd5, 1'b0, 1'b1, 1'b0);
`ifdef FETCH_CYCLE_COUNT_EN
        check("run_cycles7", run_cycles, 32'd7);
        step();
        check("run_cycles_frozen", run_cycles, 32'd7);
`endif

        // Async reset between edges
        start = 1'b1; start_pc = 32'd50;
        step();
        start = 1'b0;
        step();
        check("pre_rst", current_pc, 32'd51);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_CYCLE_COUNT_EN
        check("async_rst.cyc", run_cycles, 32'd0);
`endif
        step();
        reset = 1'b0;
        step();
        chk_out("post_rst", 32'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
